// File: rtl/dnn_weight_fetch.sv
// Weight-line fetch stage: issues 64-byte line reads and assembles eight 64-bit
// beats into one line that is handed to the weight loader with a one-cycle pulse.
module dnn_weight_fetch #(
   parameter int ADDR_W = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic              req_mem,
   output logic              mem_ready,
   output logic [63:0]       mem_data [7:0],
   output logic              rd_req_valid,
   input  logic              rd_req_ready,
   output logic [ADDR_W-1:0] rd_req_addr,
   input  logic              rd_rsp_valid,
   input  logic [63:0]       rd_rsp_data,
   output logic              busy,
   output logic [15:0]       lines_fetched
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_RSP,
      S_READY,
      S_WAIT
   } state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] line_ptr;
   logic [2:0]        beat;
   logic              pending;
   logic              take_start;

   // A new stream is only accepted while no line is in flight.
   assign take_start = start && ((state == S_IDLE) || (state == S_WAIT));

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = S_REQ;
         S_REQ:   if (rd_req_ready) state_nx = S_RSP;
         S_RSP:   if (rd_rsp_valid && (beat == 3'd7)) state_nx = S_READY;
         S_READY: state_nx = (pending || req_mem) ? S_REQ : S_WAIT;
         S_WAIT:  if (start || req_mem) state_nx = S_REQ;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         line_ptr      <= '0;
         beat          <= '0;
         pending       <= 1'b0;
         lines_fetched <= '0;
         for (int k = 0; k < 8; k++) mem_data[k] <= '0;
      end else begin
         state <= state_nx;

         if (take_start) begin
            line_ptr      <= base_addr & ~ADDR_W'(63);
            lines_fetched <= '0;
         end else if ((state == S_REQ) && rd_req_ready) begin
            line_ptr <= line_ptr + ADDR_W'(64);
            beat     <= '0;
         end

         // At most one loader request is remembered while a line is in flight.
         if (take_start || (state == S_READY))
            pending <= 1'b0;
         else if (((state == S_REQ) || (state == S_RSP)) && req_mem)
            pending <= 1'b1;

         if ((state == S_RSP) && rd_rsp_valid) begin
            mem_data[beat] <= rd_rsp_data;
            beat           <= beat + 3'd1;
         end

         if (state == S_READY)
            lines_fetched <= lines_fetched + 16'd1;
      end
   end

   assign rd_req_valid = (state == S_REQ);
   assign rd_req_addr  = line_ptr;
   assign mem_ready    = (state == S_READY);
   assign busy         = (state == S_REQ) || (state == S_RSP) || (state == S_READY);

endmodule

// File: tb/tb_dnn_weight_fetch.sv
// Randomized bench for dnn_weight_fetch: a memory responder, a transaction-level
// model of the loader-facing behaviour, and directed scenarios with literal checks.
module tb_dnn_weight_fetch;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        req_mem = 1'b0;
   logic [63:0] base_addr = '0;
   logic        rd_req_ready = 1'b0;
   logic        rd_rsp_valid = 1'b0;
   logic [63:0] rd_rsp_data = '0;

   logic        mem_ready, rd_req_valid, busy;
   logic [63:0] mem_data [7:0];
   logic [63:0] rd_req_addr;
   logic [15:0] lines_fetched;

   logic        w_mem_ready, w_rd_req_valid, w_busy;
   logic [63:0] w_mem_data [7:0];
   logic [7:0]  w_rd_req_addr;
   logic [15:0] w_lines;

   dnn_weight_fetch #(.ADDR_W(64)) u_dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .req_mem(req_mem),
      .mem_ready(mem_ready), .mem_data(mem_data), .rd_req_valid(rd_req_valid),
      .rd_req_ready(rd_req_ready), .rd_req_addr(rd_req_addr), .rd_rsp_valid(rd_rsp_valid),
      .rd_rsp_data(rd_rsp_data), .busy(busy), .lines_fetched(lines_fetched)
   );

   // Narrow-address copy sharing all stimulus; exercises pointer wrap.
   dnn_weight_fetch #(.ADDR_W(8)) u_w8 (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr[7:0]), .req_mem(req_mem),
      .mem_ready(w_mem_ready), .mem_data(w_mem_data), .rd_req_valid(w_rd_req_valid),
      .rd_req_ready(rd_req_ready), .rd_req_addr(w_rd_req_addr), .rd_rsp_valid(rd_rsp_valid),
      .rd_rsp_data(rd_rsp_data), .busy(w_busy), .lines_fetched(w_lines)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int n_rdy = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
   endtask

   // ---------------- behavioural model ----------------
   bit          m_stream, m_req, m_burst, m_rdy, m_pend;
   int          m_beats;
   logic [63:0] m_base;
   int unsigned m_issued;
   logic [15:0] m_done;
   logic [63:0] m_data [8];

   function automatic logic [63:0] m_addr();
      return m_base + (64'(m_issued) << 6);
   endfunction

   task automatic model_reset();
      m_stream = 0; m_req = 0; m_burst = 0; m_rdy = 0; m_pend = 0;
      m_beats = 0; m_base = '0; m_issued = 0; m_done = '0;
      for (int k = 0; k < 8; k++) m_data[k] = '0;
   endtask

   // One clock edge worth of loader-visible behaviour, from the inputs sampled at it.
   task automatic model_step();
      if (!(m_req || m_burst || m_rdy)) begin
         if (start) begin
            m_base = base_addr & ~64'h3F; m_issued = 0; m_done = '0;
            m_pend = 0; m_req = 1; m_stream = 1;
         end else if (m_stream && req_mem) m_req = 1;
      end else if (m_req) begin
         if (req_mem) m_pend = 1;
         if (rd_req_ready) begin m_issued++; m_req = 0; m_burst = 1; m_beats = 0; end
      end else if (m_burst) begin
         if (req_mem) m_pend = 1;
         if (rd_rsp_valid) begin
            m_data[m_beats] = rd_rsp_data;
            m_beats++;
            if (m_beats == 8) begin m_burst = 0; m_rdy = 1; end
         end
      end else begin
         m_done++;
         m_rdy = 0;
         if (m_pend || req_mem) begin m_req = 1; m_pend = 0; end
      end
   endtask

   // Compare process: inputs visible at a falling edge are those sampled at the rising edge before it.
   initial begin
      model_reset();
      forever begin
         @(negedge clk);
         if (rst) model_reset();
         else model_step();
         if (mem_ready === 1'b1) n_rdy++;
         chk("rd_req_valid", rd_req_valid, m_req);
         chk("rd_req_addr", rd_req_addr, m_addr());
         chk("mem_ready", mem_ready, m_rdy);
         chk("busy", busy, m_req | m_burst | m_rdy);
         chk("lines_fetched", lines_fetched, m_done);
         for (int k = 0; k < 8; k++) begin
            chk($sformatf("mem_data[%0d]", k), mem_data[k], m_data[k]);
            chk($sformatf("w8 mem_data[%0d]", k), w_mem_data[k], m_data[k]);
         end
         chk("w8 rd_req_addr", w_rd_req_addr, m_addr() & 64'hFF);
         chk("w8 ctrl", {w_rd_req_valid, w_mem_ready, w_busy}, {m_req, m_rdy, m_req | m_burst | m_rdy});
         chk("w8 lines_fetched", w_lines, m_done);
      end
   end

   // ---------------- memory responder ----------------
   int          to_send = 0, k_beat = 0, wcnt = 0, rdy_wait = 0, vld_pct = 100;
   bit          junk = 0, pat = 1;
   logic        p_valid = 1'b0;
   logic [63:0] p_addr = '0;
   logic [7:0]  p_addr8 = '0;
   logic [63:0] hs_q[$];
   logic [7:0]  hs8_q[$];

   initial forever begin
      bit hs;
      @(negedge clk);
      #1;
      hs = p_valid && rd_req_ready && !rst;
      if (rd_rsp_valid && to_send > 0) begin to_send--; k_beat++; end
      if (hs) begin
         to_send = 8; k_beat = 0;
         hs_q.push_back(p_addr);
         hs8_q.push_back(p_addr8);
      end
      if (!rd_req_valid) wcnt = 0;
      else if (p_valid && !hs) wcnt++;
      else wcnt = 0;
      rd_req_ready = rd_req_valid && (wcnt >= rdy_wait);
      if (to_send > 0) begin
         rd_rsp_valid = ($urandom_range(99) < vld_pct);
         rd_rsp_data  = pat ? 64'h11 * 64'(k_beat + 1) : {$urandom, $urandom};
      end else begin
         rd_rsp_valid = junk && ($urandom_range(99) < 30);
         rd_rsp_data  = {$urandom, $urandom};
      end
      p_valid = rd_req_valid;
      p_addr  = rd_req_addr;
      p_addr8 = w_rd_req_addr;
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(negedge clk);
      #2;
   endtask

   task automatic pulse_req();
      req_mem = 1'b1; tick(); req_mem = 1'b0;
   endtask

   task automatic pulse_start(input logic [63:0] b);
      base_addr = b; start = 1'b1; tick(); start = 1'b0;
   endtask

   task automatic wait_ready(output int t);
      t = -1;
      for (int i = 0; i < 200; i++) begin
         if (mem_ready) begin t = cyc; break; end
         tick();
      end
      chk("mem_ready arrives", mem_ready, 1'b1);
   endtask

   task automatic wait_burst(input int beats_done);
      for (int i = 0; i < 200; i++) begin
         if (to_send > 0 && k_beat >= beats_done) break;
         tick();
      end
      chk("burst in progress", 64'(to_send > 0 && k_beat >= beats_done), 64'd1);
   endtask

   function automatic logic [63:0] q_at(input int i);
      return (hs_q.size() > i) ? hs_q[i] : 64'hDEAD;
   endfunction

   initial begin
      int s, t, rdy0, lf0;
      #1 rst = 1'b1;
      repeat (3) tick();
      chk("reset ctrl", {mem_ready, rd_req_valid, busy}, 3'b000);
      chk("reset addr", rd_req_addr, 64'h0);
      chk("reset lines", lines_fetched, 16'h0);
      chk("reset data7", mem_data[7], 64'h0);
      rst = 1'b0;
      repeat (2) tick();

      // Single line, zero-wait memory.
      rdy0 = n_rdy;
      s = cyc;
      pulse_start(64'h1043);
      chk("t1 req valid c1", rd_req_valid, 1'b1);
      chk("t1 req addr c1", rd_req_addr, 64'h1040);
      wait_ready(t);
      chk("t1 ready latency", 64'(t - s), 64'd10);
      chk("t1 data0", mem_data[0], 64'h11);
      chk("t1 data7", mem_data[7], 64'h88);
      tick();
      chk("t1 lines", lines_fetched, 16'd1);
      chk("t1 busy", busy, 1'b0);

      // Sequential lines with request back-pressure and beat gaps.
      rdy_wait = 3; vld_pct = 60; pat = 0;
      hs_q.delete();
      for (int i = 0; i < 3; i++) begin
         pulse_req();
         wait_ready(t);
         tick();
      end
      chk("t2 handshakes", hs_q.size(), 3);
      chk("t2 addr0", q_at(0), 64'h1080);
      chk("t2 addr1", q_at(1), 64'h10C0);
      chk("t2 addr2", q_at(2), 64'h1100);
      chk("t2 lines", lines_fetched, 16'd4);
      chk("t2 ready pulses", n_rdy - rdy0, 4);

      // Queued request: two pulses in RSP, one in READY -> one extra line.
      rdy_wait = 0; vld_pct = 25;
      hs_q.delete();
      lf0 = lines_fetched;
      pulse_req();
      wait_burst(0);
      pulse_req();
      tick();
      pulse_req();
      wait_ready(t);
      req_mem = 1'b1; tick(); req_mem = 1'b0;
      chk("t3 no wait gap", rd_req_valid, 1'b1);
      wait_ready(t);
      tick();
      repeat (20) tick();
      chk("t3 handshakes", hs_q.size(), 2);
      chk("t3 addr0", q_at(0), 64'h1140);
      chk("t3 addr1", q_at(1), 64'h1180);
      chk("t3 lines", lines_fetched, 16'(lf0 + 2));

      // Address wrap on the narrow instance.
      rdy_wait = 1; vld_pct = 100; pat = 1;
      hs_q.delete(); hs8_q.delete();
      pulse_start(64'hC0);
      wait_ready(t); tick();
      pulse_req();
      wait_ready(t); tick();
      chk("t4 w8 handshakes", hs8_q.size(), 2);
      chk("t4 w8 addr0", (hs8_q.size() > 0) ? hs8_q[0] : 8'h55, 8'hC0);
      chk("t4 w8 addr1", (hs8_q.size() > 1) ? hs8_q[1] : 8'h55, 8'h00);
      chk("t4 addr1", q_at(1), 64'h100);
      chk("t4 lines", lines_fetched, 16'd2);

      // start ignored mid-line; start wins over req_mem in WAIT.
      vld_pct = 40;
      hs_q.delete();
      pulse_req();
      wait_burst(0);
      pulse_start(64'h2000);
      wait_ready(t); tick();
      pulse_req();
      wait_ready(t); tick();
      chk("t5 addr0", q_at(0), 64'h140);
      chk("t5 addr1", q_at(1), 64'h180);
      chk("t5 lines", lines_fetched, 16'd4);
      req_mem = 1'b1;
      pulse_start(64'h2000);
      req_mem = 1'b0;
      chk("t5 lines cleared", lines_fetched, 16'd0);
      chk("t5 new base", rd_req_addr, 64'h2000);
      wait_ready(t); tick();
      chk("t5 lines after", lines_fetched, 16'd1);

      // Reset after five beats; the tail of the burst must be ignored.
      vld_pct = 100; rdy_wait = 0;
      pulse_req();
      wait_burst(5);
      rst = 1'b1;
      #1;
      chk("t6 async ctrl", {mem_ready, rd_req_valid, busy}, 3'b000);
      chk("t6 async addr", rd_req_addr, 64'h0);
      chk("t6 async lines", lines_fetched, 16'h0);
      chk("t6 async data0", mem_data[0], 64'h0);
      rdy0 = n_rdy;
      tick();
      rst = 1'b0;
      repeat (6) tick();
      chk("t6 tail ignored", mem_data[5], 64'h0);
      chk("t6 no pulse", n_rdy - rdy0, 0);
      pulse_start(64'h3000);
      wait_ready(t);
      chk("t6 fresh data0", mem_data[0], 64'h11);
      chk("t6 fresh data5", mem_data[5], 64'h66);
      chk("t6 fresh data7", mem_data[7], 64'h88);
      tick();
      chk("t6 lines", lines_fetched, 16'd1);

      // Random traffic with stray beats and occasional resets.
      junk = 1; pat = 0;
      for (int i = 0; i < 1500; i++) begin
         req_mem   = ($urandom_range(99) < 12);
         start     = ($urandom_range(99) < 3);
         base_addr = {$urandom, $urandom};
         rdy_wait  = $urandom_range(3);
         vld_pct   = $urandom_range(100, 40);
         rst       = ($urandom_range(999) < 4);
         tick();
      end
      rst = 1'b0; start = 1'b0; req_mem = 1'b0; junk = 0;
      repeat (4) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_chk);
      $fatal(1, "watchdog expired");
   end

endmodule
